// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected MAC layer.
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_EMIT
  } fc_state_e;

  // Address width for an index range of n entries, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp v to the signed range of a w-bit word; caller truncates to w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational requantisation: fraction shift, bias add, optional ReLU, saturate.
module fc_requant
  import fc_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned W_FRAC  = 7,
  parameter bit          RELU_EN = 1'b0
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [OUT_W-1:0] bias,
  output logic signed [OUT_W-1:0] res
);

  logic signed [ACC_W-1:0] r;

  always_comb begin
    r = (acc >>> W_FRAC) + ACC_W'(bias);
    if (RELU_EN && r[ACC_W-1]) r = '0;
    res = OUT_W'(sat_to(64'(r), OUT_W));
  end

endmodule

// File: rtl/fc_layer_mac.sv
// Fully-connected layer: buffers one input vector, then runs a sequential MAC per neuron.
module fc_layer_mac
  import fc_pkg::*;
#(
  parameter int unsigned N_IN    = 16,
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned W_W     = 8,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned W_FRAC  = 7,
  parameter bit          RELU_EN = 1'b0,
  localparam int unsigned WA_W   = addr_w(N_IN * N_OUT),
  localparam int unsigned BA_W   = addr_w(N_OUT),
  localparam int unsigned I_W    = addr_w(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fc_en,
  input  logic [IN_W-1:0]   in_data,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [WA_W-1:0]   weight_addr,
  input  logic [W_W-1:0]    weight,
  output logic [BA_W-1:0]   bias_addr,
  input  logic [OUT_W-1:0]  bias,
  output logic [OUT_W-1:0]  out,
  output logic [BA_W-1:0]   out_idx,
  output logic              valid_out,
  output logic              done,
  output logic              busy
);

  fc_state_e               state_q, state_d;
  logic [I_W-1:0]          in_cnt_q, in_cnt_d;
  logic [I_W-1:0]          i_q, i_d;
  logic [I_W-1:0]          i_dly_q, i_dly_d;
  logic                    mac_vld_q, mac_vld_d;
  logic [BA_W-1:0]         j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [IN_W-1:0]  smp_q [N_IN];
  logic signed [IN_W-1:0]  smp_d [N_IN];
  logic [OUT_W-1:0]        out_q, out_d;
  logic [BA_W-1:0]         out_idx_q, out_idx_d;
  logic                    valid_out_q, valid_out_d;
  logic                    done_q, done_d;
  logic signed [ACC_W-1:0] prod;
  logic signed [OUT_W-1:0] rq_res;

  // Weight memory has one cycle of latency, so the product uses the index issued last cycle.
  assign prod = ACC_W'(smp_q[i_dly_q]) * ACC_W'($signed(weight));

  fc_requant #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .W_FRAC (W_FRAC),
    .RELU_EN(RELU_EN)
  ) u_requant (
    .acc (acc_q),
    .bias($signed(bias)),
    .res (rq_res)
  );

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    i_d         = i_q;
    i_dly_d     = i_q;
    mac_vld_d   = 1'b0;
    j_d         = j_q;
    acc_d       = acc_q;
    smp_d       = smp_q;
    out_d       = out_q;
    out_idx_d   = out_idx_q;
    valid_out_d = 1'b0;
    done_d      = 1'b0;
    if (mac_vld_q) acc_d = acc_q + prod;
    case (state_q)
      S_IDLE: begin
        if (fc_en) begin
          state_d  = S_LOAD;
          in_cnt_d = '0;
          i_d      = '0;
          j_d      = '0;
          acc_d    = '0;
        end
      end
      S_LOAD: begin
        if (valid_in) begin
          smp_d[in_cnt_q] = in_data;
          in_cnt_d        = in_cnt_q + I_W'(1);
          if (in_cnt_q == I_W'(N_IN - 1)) begin
            state_d = S_MAC;
            i_d     = '0;
          end
        end
      end
      S_MAC: begin
        mac_vld_d = 1'b1;
        if (i_q == I_W'(N_IN - 1)) begin
          i_d     = '0;
          state_d = S_DRAIN;
        end else begin
          i_d = i_q + I_W'(1);
        end
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        out_d       = rq_res;
        out_idx_d   = j_q;
        valid_out_d = 1'b1;
        acc_d       = '0;
        if (j_q == BA_W'(N_OUT - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          j_d     = j_q + BA_W'(1);
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      i_q         <= '0;
      i_dly_q     <= '0;
      mac_vld_q   <= 1'b0;
      j_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_idx_q   <= '0;
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      i_q         <= i_d;
      i_dly_q     <= i_dly_d;
      mac_vld_q   <= mac_vld_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_idx_q   <= out_idx_d;
      valid_out_q <= valid_out_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    smp_q <= smp_d;
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign weight_addr = WA_W'(int'(j_q) * N_IN + int'(i_q));
  assign bias_addr   = j_q;
  assign out         = out_q;
  assign out_idx     = out_idx_q;
  assign valid_out   = valid_out_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fc_layer_mac.sv
// Directed bench for fc_layer_mac with N_IN=4, N_OUT=2; plain and ReLU instances share stimulus.
module tb_fc_layer_mac;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fc_en;
  logic [15:0] in_data;
  logic        valid_in;

  logic        in_ready, valid_out, done, busy;
  logic [2:0]  weight_addr;
  logic [0:0]  bias_addr, out_idx;
  logic [7:0]  weight;
  logic [15:0] bias, out;

  logic        in_ready_r, valid_out_r, done_r, busy_r;
  logic [2:0]  weight_addr_r;
  logic [0:0]  bias_addr_r, out_idx_r;
  logic [7:0]  weight_r;
  logic [15:0] bias_r, out_r;

  logic signed [15:0] xin  [4];
  logic signed [7:0]  wmem [8];
  logic signed [15:0] bmem [2];

  typedef struct {
    logic signed [15:0] val;
    int                 idx;
    bit                 dn;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_vo = 0;
  bit tim_chk = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    weight   <= wmem[weight_addr];
    bias     <= bmem[bias_addr];
    weight_r <= wmem[weight_addr_r];
    bias_r   <= bmem[bias_addr_r];
  end

  fc_layer_mac #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(16), .W_W(8), .OUT_W(16),
    .ACC_W(32), .W_FRAC(7), .RELU_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .fc_en(fc_en), .in_data(in_data), .valid_in(valid_in),
    .in_ready(in_ready), .weight_addr(weight_addr), .weight(weight),
    .bias_addr(bias_addr), .bias(bias), .out(out), .out_idx(out_idx),
    .valid_out(valid_out), .done(done), .busy(busy)
  );

  fc_layer_mac #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(16), .W_W(8), .OUT_W(16),
    .ACC_W(32), .W_FRAC(7), .RELU_EN(1'b1)
  ) dut_r (
    .clk(clk), .rst(rst), .fc_en(fc_en), .in_data(in_data), .valid_in(valid_in),
    .in_ready(in_ready_r), .weight_addr(weight_addr_r), .weight(weight_r),
    .bias_addr(bias_addr_r), .bias(bias_r), .out(out_r), .out_idx(out_idx_r),
    .valid_out(valid_out_r), .done(done_r), .busy(busy_r)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input int val, input int idx, input bit dn);
    exp_t e;
    e.val = 16'(val);
    e.idx = idx;
    e.dn  = dn;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Scoreboard: every valid_out pops one expectation per instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_out) begin
        if (q0.size() == 0) chk("dut_unexpected_valid", q0.size(), 1);
        else begin
          e = q0.pop_front();
          chk("dut_out", $signed(out), e.val);
          chk("dut_out_idx", out_idx, e.idx);
          chk("dut_done", done, e.dn);
          if (done) chk("dut_busy_at_done", busy, 0);
          if (tim_chk) begin
            if (e.idx == 0) chk("first_out_latency", cyc - last_acc, N_IN + 2);
            else chk("neuron_period", cyc - last_vo, N_IN + 2);
          end
          last_vo = cyc;
        end
      end else begin
        chk("dut_done_without_valid", done, 0);
      end
      if (valid_out_r) begin
        if (q1.size() == 0) chk("relu_unexpected_valid", q1.size(), 1);
        else begin
          e = q1.pop_front();
          chk("relu_out", $signed(out_r), e.val);
          chk("relu_out_idx", out_idx_r, e.idx);
          chk("relu_done", done_r, e.dn);
        end
      end
    end
  end

  task automatic set_x(input int a, input int b, input int c, input int d);
    xin[0] = 16'(a); xin[1] = 16'(b); xin[2] = 16'(c); xin[3] = 16'(d);
  endtask

  task automatic set_w(input int j, input int a, input int b, input int c, input int d);
    wmem[j*4+0] = 8'(a); wmem[j*4+1] = 8'(b); wmem[j*4+2] = 8'(c); wmem[j*4+3] = 8'(d);
  endtask

  task automatic do_run(input bit gap, input bit disturb, input bit tim, input bit abort);
    int n;
    tim_chk = tim;
    @(negedge clk); fc_en = 1'b1;
    @(negedge clk); fc_en = 1'b0;
    chk("in_ready_in_load", in_ready, 1);
    chk("relu_in_ready_in_load", in_ready_r, 1);
    for (int k = 0; k < 4; k++) begin
      if (gap && k > 0) begin
        valid_in = 1'b0;
        @(negedge clk);
      end
      valid_in = 1'b1;
      in_data  = xin[k];
      @(posedge clk);
      #1 last_acc = cyc;
      @(negedge clk);
    end
    valid_in = 1'b0;
    if (abort) begin
      @(negedge clk);
      chk("busy_in_mac", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out", out, 0);
      chk("abort_valid_out", valid_out, 0);
      chk("abort_done", done, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_weight_addr", weight_addr, 0);
      chk("abort_bias_addr", bias_addr, 0);
      q0.delete();
      q1.delete();
      rst = 1'b0;
      tim_chk = 1'b0;
      @(negedge clk);
      return;
    end
    if (disturb) begin
      valid_in = 1'b1;
      in_data  = 16'h7fff;
      fc_en    = 1'b1;
      @(negedge clk);
      fc_en = 1'b0;
      @(negedge clk);
      valid_in = 1'b0;
    end
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_within_budget", n < 100, 1);
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("relu_idle_busy", busy_r, 0);
    tim_chk = 1'b0;
  endtask

  task automatic basic_setup();
    set_x(256, 512, -256, 128);
    set_w(0, 64, 64, 64, 64);
    set_w(1, 127, 127, 127, 127);
    bmem[0] = 16'sd16;
    bmem[1] = -16'sd1000;
    push(0, 336, 0, 0);
    push(0, -365, 1, 1);
    push(1, 336, 0, 0);
    push(1, 0, 1, 1);
  endtask

  initial begin
    rst = 1'b1; fc_en = 1'b0; valid_in = 1'b0; in_data = '0;
    set_x(0, 0, 0, 0);
    set_w(0, 0, 0, 0, 0);
    set_w(1, 0, 0, 0, 0);
    bmem[0] = '0; bmem[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_weight_addr", weight_addr, 0);
    chk("rst_bias_addr", bias_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic (plain) and ReLU results, with latency/period timing.
    basic_setup();
    do_run(1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped valid_in plus stray valid_in and fc_en during the run.
    basic_setup();
    do_run(1'b1, 1'b1, 1'b0, 1'b0);

    // Positive and negative saturation.
    set_x(32767, 32767, 32767, 32767);
    set_w(0, 127, 127, 127, 127);
    set_w(1, 127, 127, 127, 127);
    bmem[0] = '0; bmem[1] = '0;
    push(0, 32767, 0, 0); push(0, 32767, 1, 1);
    push(1, 32767, 0, 0); push(1, 32767, 1, 1);
    do_run(1'b0, 1'b0, 1'b0, 1'b0);
    set_w(0, -128, -128, -128, -128);
    set_w(1, -128, -128, -128, -128);
    push(0, -32768, 0, 0); push(0, -32768, 1, 1);
    push(1, 0, 0, 0); push(1, 0, 1, 1);
    do_run(1'b0, 1'b0, 1'b0, 1'b0);

    // Floor shift of a tiny negative accumulator, with timing.
    set_x(-1, 0, 0, 0);
    set_w(0, 1, 0, 0, 0);
    set_w(1, 0, 0, 0, 0);
    push(0, -1, 0, 0); push(0, 0, 1, 1);
    push(1, 0, 0, 0); push(1, 0, 1, 1);
    do_run(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during MAC of neuron 0, then a fresh basic run.
    basic_setup();
    do_run(1'b0, 1'b0, 1'b0, 1'b1);
    basic_setup();
    do_run(1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
